// File: rtl/lu_pkg.sv
// Shared definitions for the 24-bit logic unit: word width, opcodes and the evaluation function.
// Ports carry words with bit 0 as the MSB; word_rev converts between port order and value order.
package lu_pkg;

    localparam int WORD_W = 24;

    typedef enum logic [1:0] {
        LU_AND  = 2'b00,
        LU_OR   = 2'b01,
        LU_XOR  = 2'b10,
        LU_ANDC = 2'b11
    } lu_op_e;

    function automatic logic [WORD_W-1:0] lu_eval(input logic [1:0] op,
                                                   input logic [WORD_W-1:0] a,
                                                   input logic [WORD_W-1:0] b);
        logic [WORD_W-1:0] y;
        case (lu_op_e'(op))
            LU_AND:  y = a & b;
            LU_OR:   y = a | b;
            LU_XOR:  y = a ^ b;
            default: y = a & ~b;
        endcase
        return y;
    endfunction

    function automatic logic [WORD_W-1:0] word_rev(input logic [WORD_W-1:0] w);
        logic [WORD_W-1:0] r;
        for (int k = 0; k < WORD_W; k++) begin
            r[k] = w[WORD_W-1-k];
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first request after `pointer`, wrapping at N-1.
// The pointer register lives in the parent; `enable` low forces an all-zero grant.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 3
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] pointer,
    input  logic           enable,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] index
);

    always_comb begin
        grant = '0;
        index = '0;
        if (enable) begin
            // Walk offsets from farthest to nearest so the nearest valid requester wins.
            for (int off = N; off >= 1; off--) begin
                for (int i = 0; i < N; i++) begin
                    if (req[i] && (i == ((int'(pointer) + off) % N))) begin
                        grant = N'(1) << i;
                        index = IDW'(i);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin shared 24-bit logic unit with a single registered valid/ready output stage.
// Define LU_ZERO_FLAG_EN to add the registered rsp_zero output.
module logic_unit_arbiter
    import lu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [2*NUM_REQ-1:0]        req_op,
    input  logic [WORD_W*NUM_REQ-1:0]   req_a,
    input  logic [WORD_W*NUM_REQ-1:0]   req_b,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [ID_W-1:0]             rsp_id,
    output logic [WORD_W-1:0]           rsp_y
`ifdef LU_ZERO_FLAG_EN
    ,
    output logic                        rsp_zero
`endif
);

    logic                 stage_free;
    logic                 arb_en;
    logic [NUM_REQ-1:0]   grant;
    logic [ID_W-1:0]      grant_idx;
    logic [ID_W-1:0]      rr_ptr;
    logic [1:0]           sel_op;
    logic [WORD_W-1:0]    sel_a;
    logic [WORD_W-1:0]    sel_b;
    logic [WORD_W-1:0]    y_next;

    // The stage can take a new result when empty or when its current result leaves this cycle.
    assign stage_free = !rsp_valid || rsp_ready;
    // Holding grants low while reset is asserted keeps req_ready at zero during reset.
    assign arb_en     = stage_free && rst_n;

    rr_arbiter #(
        .N   (NUM_REQ),
        .IDW (ID_W)
    ) u_rr (
        .req     (req_valid),
        .pointer (rr_ptr),
        .enable  (arb_en),
        .grant   (grant),
        .index   (grant_idx)
    );

    assign req_ready = grant;

    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_op = {req_op[2*i], req_op[2*i+1]};
                sel_a  = word_rev(req_a[WORD_W*i +: WORD_W]);
                sel_b  = word_rev(req_b[WORD_W*i +: WORD_W]);
            end
        end
    end

    assign y_next = lu_eval(sel_op, sel_a, sel_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_y     <= '0;
            rsp_id    <= '0;
            rr_ptr    <= ID_W'(NUM_REQ - 1);
        end else if (|grant) begin
            rsp_valid <= 1'b1;
            rsp_y     <= word_rev(y_next);
            rsp_id    <= grant_idx;
            rr_ptr    <= grant_idx;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef LU_ZERO_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_zero <= 1'b0;
        end else if (|grant) begin
            rsp_zero <= (y_next == '0);
        end
    end
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter: directed requests push expected results, a monitor pops them.
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
module tb_logic_unit_arbiter;
    import lu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [7:0]  req_op;
    logic [95:0] req_a;
    logic [95:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [2:0]  rsp_id;
    logic [23:0] rsp_y;
`ifdef LU_ZERO_FLAG_EN
    logic        rsp_zero;
`endif

    int checks;
    int failures;
    logic [26:0] exp_q[$];
    logic [26:0] mon_e;

    logic_unit_arbiter #(
        .NUM_REQ (4),
        .ID_W    (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y)
`ifdef LU_ZERO_FLAG_EN
        ,
        .rsp_zero  (rsp_zero)
`endif
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [23:0] rev24(input logic [23:0] v);
        logic [23:0] r;
        for (int k = 0; k < 24; k++) r[k] = v[23-k];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic set_req(input int i, input logic [1:0] op, input logic [23:0] a, input logic [23:0] b);
        req_op[2*i]      = op[1];
        req_op[2*i+1]    = op[0];
        req_a[24*i +: 24] = rev24(a);
        req_b[24*i +: 24] = rev24(b);
    endtask

    task automatic issue(input int i, input logic [1:0] op, input logic [23:0] a,
                         input logic [23:0] b, input logic [23:0] exp_y);
        set_req(i, op, a, b);
        req_valid[i] = 1'b1;
        @(negedge clk);
        check("grant", 32'(req_ready), 32'(4'b0001 << i));
        exp_q.push_back({3'(i), exp_y});
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp: got id %0h y %0h expected none", rsp_id, rev24(rsp_y));
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(mon_e[26:24]));
                check("rsp_y", 32'(rev24(rsp_y)), 32'(mon_e[23:0]));
`ifdef LU_ZERO_FLAG_EN
                check("rsp_zero", 32'(rsp_zero), 32'(mon_e[23:0] == 24'h0));
`endif
            end
        end
    end

    logic [23:0] fair_y [4];

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        fair_y[0] = 24'h00000F;
        fair_y[1] = 24'hFF1FFF;
        fair_y[2] = 24'hFF1FF0;
        fair_y[3] = 24'hF010F0;

        // reset state, with all requesters valid
        repeat (2) @(posedge clk);
        #1;
        check("reset_req_ready", 32'(req_ready), 32'h0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_rsp_id", 32'(rsp_id), 32'h0);
        check("reset_rsp_y", 32'(rsp_y), 32'h0);
        req_valid = 4'h0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single requester
        issue(0, LU_AND, 24'hF010FF, 24'hFFF000, 24'hF01000);
        issue(0, LU_AND, 24'hF010FF, 24'h000000, 24'h000000);

        // opcode sweep on requester 1
        issue(1, LU_OR,   24'hF010FF, 24'h000F00, 24'hF01FFF);
        issue(1, LU_XOR,  24'hF010FF, 24'hFFFFFF, 24'h0FEF00);
        issue(1, LU_ANDC, 24'hF010FF, 24'hFFF000, 24'h0000FF);

        // park the pointer at 3 so requester 0 is next
        issue(3, LU_AND, 24'h123456, 24'hFFFFFF, 24'h123456);

        // fairness: all four valid for 8 cycles
        set_req(0, LU_AND,  24'hF010FF, 24'h0F0F0F);
        set_req(1, LU_OR,   24'hF010FF, 24'h0F0F0F);
        set_req(2, LU_XOR,  24'hF010FF, 24'h0F0F0F);
        set_req(3, LU_ANDC, 24'hF010FF, 24'h0F0F0F);
        req_valid = 4'hF;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("fair_grant", 32'(req_ready), 32'(4'b0001 << (c % 4)));
            exp_q.push_back({3'(c % 4), fair_y[c % 4]});
            @(posedge clk);
            #1;
        end
        req_valid = 4'h0;

        // backpressure
        set_req(0, LU_XOR, 24'hAAAAAA, 24'h555555);
        set_req(1, LU_AND, 24'hAAAAAA, 24'h555555);
        req_valid = 4'b0011;
        @(negedge clk);
        check("bp_first_grant", 32'(req_ready), 32'h1);
        exp_q.push_back({3'd0, 24'hFFFFFF});
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_req_ready", 32'(req_ready), 32'h0);
            check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
            check("bp_rsp_id", 32'(rsp_id), 32'h0);
            check("bp_rsp_y", 32'(rev24(rsp_y)), 32'hFFFFFF);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_grant", 32'(req_ready), 32'h2);
        exp_q.push_back({3'd1, 24'h000000});
        @(posedge clk);
        #1;
        req_valid = 4'h0;
        rsp_ready = 1'b0;

        // reset mid-stream with a result held
        set_req(2, LU_OR,  24'h000001, 24'h000002);
        set_req(3, LU_AND, 24'h00FF00, 24'h0F0F0F);
        req_valid = 4'b1100;
        @(negedge clk);
        check("pre_reset_rsp_valid", 32'(rsp_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rsp_valid", 32'(rsp_valid), 32'h0);
        check("async_rsp_y", 32'(rsp_y), 32'h0);
        check("async_rsp_id", 32'(rsp_id), 32'h0);
        check("async_req_ready", 32'(req_ready), 32'h0);
        exp_q.delete();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_grant", 32'(req_ready), 32'h4);
        exp_q.push_back({3'd2, 24'h000003});
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        @(negedge clk);
        check("post_reset_second", 32'(req_ready), 32'h8);
        exp_q.push_back({3'd3, 24'h000F00});
        @(posedge clk);
        #1;
        req_valid = 4'h0;

        // drain and report
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
Shares one 24-bit logic unit (AND / OR / XOR / AND-complement) between NUM_REQ requesters, such as decode, address-generation and debug paths.
- Round-robin arbitration: at most one grant per cycle.
- The operation is evaluated combinationally and the result is registered in a single output stage with a valid/ready handshake.
- Sits in the CPU24 execute stage, in front of the register-file write-back mux.

Parameters:
NUM_REQ, 4, number of requesters (legal 2..8).
ID_W, 3, width of the requester id on the response (must satisfy 2**ID_W >= NUM_REQ).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  NUM_REQ  per-requester request valid.
req_ready  out  NUM_REQ  per-requester grant; the request is accepted on the cycle where valid and ready are both high.
req_op  in  2*NUM_REQ  per-requester opcode, requester i at slice [2i:2i+1].
req_a  in  24*NUM_REQ  operand A; bit 0 is the MSB of each 24-bit slice.
req_b  in  24*NUM_REQ  operand B, same layout as req_a.
rsp_valid  out  1  result register holds valid data.
rsp_ready  in  1  consumer accepts the result.
rsp_id  out  ID_W  index of the requester that owns the result.
rsp_y  out  24  result, bit 0 is the MSB.

Behaviour:
- Reset, asserted asynchronously:
  - rsp_valid=0, rsp_y=0, rsp_id=0, req_ready=0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
- Opcodes:
  - 00 AND: y = a & b.
  - 01 OR: y = a | b.
  - 10 XOR: y = a ^ b.
  - 11 ANDC: y = a & ~b.
- Output stage is free when rsp_valid==0, or when rsp_valid && rsp_ready in the same cycle (pass-through, no bubble).
- Arbitration (combinational, every cycle):
  - If the output stage is free, grant the first valid requester searching from pointer+1 upward, wrapping at NUM_REQ-1 to 0.
  - req_ready is one-hot or all zero; req_ready[i] never asserts unless req_valid[i] is high.
- Accept, on a clock edge with a grant to requester g:
  - rsp_y <= op(a_g, b_g); rsp_id <= g; rsp_valid <= 1; pointer <= g.
- Latency: exactly 1 cycle from accept to rsp_valid.
- Consume without a new grant: rsp_valid <= 0. rsp_y and rsp_id hold their last values.
- Backpressure: while rsp_valid && !rsp_ready, there are no grants and rsp_y/rsp_id/rsp_valid stay stable. A requester must hold its valid and operands until granted.
- No requests: the pointer is unchanged and no state moves.
- Throughput: one result per cycle sustained when rsp_ready stays high.
- Fairness: with all requesters continuously valid, grant order is 0,1,..,NUM_REQ-1,0,... with no requester starved for more than NUM_REQ-1 grants.
- Reset mid-operation: any in-flight result is discarded. The first grant after rst_n deasserts goes to the lowest-indexed valid requester.
- Unknown or X opcodes do not occur; no error handling is provided.

Optional Feature:
Macro LU_ZERO_FLAG_EN.
- Defined: adds output port rsp_zero (1 bit), registered alongside rsp_y. It is 1 when the result equals 24'h000000, resets to 0, and holds under backpressure.
- Undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Package lu_pkg holds:
  - WORD_W = 24.
  - Opcode constants LU_AND=2'b00, LU_OR=2'b01, LU_XOR=2'b10, LU_ANDC=2'b11.
  - Function lu_eval(op, a, b), shared with the existing AndOp/OrOp units.
- Sub-module rr_arbiter (parameter N): inputs req[N], pointer and enable; outputs a one-hot grant and the encoded index. It is purely combinational; the pointer register stays in the parent.

Test Plan:
1. Single requester: req0 sends AND, a=F010FF, b=FFF000, with rsp_ready=1. Expect rsp_valid one cycle later, rsp_y=F01000, rsp_id=0. With b=000000 expect rsp_y=000000 (rsp_zero=1 if LU_ZERO_FLAG_EN).
2. Opcode sweep on req1 with a=F010FF:
   - OR, b=000F00 -> F01FFF.
   - XOR, b=FFFFFF -> 0FEF00.
   - ANDC, b=FFF000 -> 0000FF.
   rsp_id=1 on all three.
3. Fairness: all 4 requesters held valid for 8 cycles with rsp_ready=1. Expect grants 0,1,2,3,0,1,2,3 on consecutive cycles and rsp_id following the same order.
4. Backpressure: rsp_ready=0 for 3 cycles while results are pending. Expect req_ready=0, and rsp_y/rsp_id stable for those cycles. Raise rsp_ready and expect the next grant in the same cycle, with no bubble.
5. Reset mid-stream: assert rst_n=0 asynchronously between clock edges while rsp_valid=1. Expect rsp_valid, rsp_y and req_ready to clear immediately. After release with req2 and req3 valid, expect the first grant to go to req2.
